mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle control unit for the MIPS multi-cycle processor, directly upstream of the datapath. It consumes the datapath's `OPCode`, `Funct` and `Z`, and drives every datapath control input (`PCEn`, `IorD`, `MemWrite`, `IRWrite`, `RegDst`, `MemtoReg`, `RegWrite`, `ALUSrcA`, `PCSrc`, `ALUSrcB`, `ALUCtrl`). The core is a Moore main FSM sequencing fetch/decode/execute for lw, sw, R-type (add/sub/and/or/slt), beq, addi and j, plus a combinational ALU decoder.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `OPCode` in 6: instruction[31:26] from the IR.
- `Funct` in 6: instruction[5:0] from the IR.
- `Z` in 1: combinational ALU zero flag.
- `PCEn` out 1: PC register enable, `PCWrite | (Branch & Z)`.
- `IorD` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction register enable.
- `RegDst` out 1: write-register select, 0 = rt, 1 = rd.
- `MemtoReg` out 1: write-data select, 0 = ALUOut, 1 = Data.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A select, 0 = PC, 1 = rs register.
- `ALUSrcB` out 2: ALU B select, 00 = rt register, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `PCSrc` out 2: next-PC select, 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `ALUCtrl` out 3: ALU operation, 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `IllegalOp` out 1: one-cycle pulse in DECODE for an unsupported opcode or funct.
- `InstrDone` out 1: one-cycle pulse in the final state of each instruction.

## Operation
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- Funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- ALUOp (internal, 2 bits): 00 selects add, 01 selects sub, 10 decodes Funct.
- All outputs not listed for a state are 0. Default `ALUCtrl` is 010.
- FSM states and assertions:
  - FETCH: IorD=0, IRWrite, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite. Next state is DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (computes branch target into ALUOut). Next state by opcode:
    - lw or sw → MEMADR
    - R-type with a legal funct → EXECUTE
    - beq → BRANCH
    - addi → ADDIEX
    - j → JUMP
    - anything else → FETCH, with IllegalOp asserted.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMRD for lw, MEMWR for sw.
  - MEMRD: IorD=1. Next state is MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite, InstrDone. Next state is FETCH.
  - MEMWR: IorD=1, MemWrite, InstrDone. Next state is FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite, InstrDone. Next state is FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch, InstrDone. Next state is FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite, InstrDone. Next state is FETCH.
  - JUMP: PCSrc=10, PCWrite, InstrDone. Next state is FETCH.
- Illegal handling: the PC has already advanced by 4 in FETCH, so an illegal instruction behaves as a nop.

## Timing
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- State register updates on the rising edge of `clk`.
- All outputs except `PCEn` are Moore (decoded from state only). `PCEn` is combinational in `Z` during BRANCH.
- While `reset` is low:
  - The state is held at FETCH.
  - `PCEn`, `IRWrite`, `MemWrite`, `RegWrite`, `IllegalOp` and `InstrDone` are forced to 0.
  - All other outputs take their FETCH values.
- Reset asserted mid-instruction aborts it immediately: no partial write occurs after assertion.
- The first rising edge after `reset` goes high executes FETCH.
- `OPCode` and `Funct` are sampled only in DECODE and later states. The IR is stable after FETCH because IRWrite is 0 elsewhere.
- `Z` is consumed only in BRANCH. Glitches on `Z` in other states must not affect `PCEn`.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the 4-bit state encoding, with FETCH = 4'd0;
  - opcode and funct constants;
  - ALUOp and ALUCtrl encodings;
  - the ALUSrcB and PCSrc select constants.
- Sub-module `alu_decoder` (combinational): inputs ALUOp and Funct; outputs ALUCtrl and a `functLegal` flag used by DECODE.
- `mc_controller` contains the state register, next-state logic, output decode and the PCEn equation.

## Test plan
- Reset low for 3 cycles mid-MEMRD, then release → state is FETCH; IRWrite/PCEn/RegWrite/MemWrite are 0 during reset; first post-reset cycle has IRWrite=1, PCEn=1, ALUSrcB=01.
- OPCode=100011 (lw) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1, MemtoReg=1 only in cycle 5; InstrDone pulses once.
- OPCode=000000, Funct=101010 → EXECUTE has ALUCtrl=111; ALUWB has RegDst=1, RegWrite=1; 4 cycles total.
- OPCode=000100 with Z=1, then repeated with Z=0 → PCEn=1, PCSrc=01 in BRANCH; with Z=0, PCEn=0; back to FETCH after 3 cycles either way.
- OPCode=000010 → JUMP has PCSrc=10, PCEn=1; OPCode=101011 → MEMWR has MemWrite=1, IorD=1.
- OPCode=111111, then OPCode=000000 with Funct=000001 → IllegalOp pulses in DECODE; next state FETCH; no RegWrite or MemWrite asserted.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// funct codes, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [2:0] AluCtrlAdd = 3'b010;
  localparam logic [2:0] AluCtrlSub = 3'b110;
  localparam logic [2:0] AluCtrlAnd = 3'b000;
  localparam logic [2:0] AluCtrlOr  = 3'b001;
  localparam logic [2:0] AluCtrlSlt = 3'b111;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp/Funct to ALUCtrl and flags whether
// Funct is one of the supported R-type operations.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_e    ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUCtrl,
  output logic       functLegal
);

  logic [2:0] funct_ctrl;

  always_comb begin
    funct_ctrl = AluCtrlAdd;
    functLegal = 1'b1;
    case (Funct)
      FunctAdd: funct_ctrl = AluCtrlAdd;
      FunctSub: funct_ctrl = AluCtrlSub;
      FunctAnd: funct_ctrl = AluCtrlAnd;
      FunctOr:  funct_ctrl = AluCtrlOr;
      FunctSlt: funct_ctrl = AluCtrlSlt;
      default:  functLegal = 1'b0;
    endcase
  end

  always_comb begin
    ALUCtrl = AluCtrlAdd;
    case (ALUOp)
      AluOpSub:   ALUCtrl = AluCtrlSub;
      AluOpFunct: ALUCtrl = funct_ctrl;
      default:    ALUCtrl = AluCtrlAdd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: Moore main FSM plus ALU decoder; only PCEn
// depends combinationally on an input (Z, during BRANCH).
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCode,
  input  logic [5:0] Funct,
  input  logic       Z,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUCtrl,
  output logic       IllegalOp,
  output logic       InstrDone
);

  state_e  state_q, state_d;
  alu_op_e alu_op;
  logic    funct_legal;
  logic    pc_write, branch;
  logic    mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw, done_raw;

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .Funct      (Funct),
    .ALUCtrl    (ALUCtrl),
    .functLegal (funct_legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    alu_op        = AluOpAdd;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SrcBReg;
    PCSrc         = PcSrcAlu;
    pc_write      = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    done_raw      = 1'b0;
    unique case (state_q)
      StFetch: begin
        ir_write_raw = 1'b1;
        ALUSrcB      = SrcBFour;
        pc_write     = 1'b1;
        state_d      = StDecode;
      end
      StDecode: begin
        ALUSrcB = SrcBImmSh;
        case (OPCode)
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          OpRtype: begin
            state_d     = funct_legal ? StExecute : StFetch;
            illegal_raw = ~funct_legal;
          end
          default: begin
            state_d     = StFetch;
            illegal_raw = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = (OPCode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        IorD    = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = StFetch;
      end
      StMemWr: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = StFetch;
      end
      StExecute: begin
        ALUSrcA = 1'b1;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = StFetch;
      end
      StBranch: begin
        ALUSrcA  = 1'b1;
        alu_op   = AluOpSub;
        PCSrc    = PcSrcAluOut;
        branch   = 1'b1;
        done_raw = 1'b1;
        state_d  = StFetch;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
        state_d       = StFetch;
      end
      StJump: begin
        PCSrc    = PcSrcJump;
        pc_write = 1'b1;
        done_raw = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Write strobes are gated by reset so nothing commits while it is held low.
  assign PCEn      = reset & (pc_write | (branch & Z));
  assign IRWrite   = reset & ir_write_raw;
  assign MemWrite  = reset & mem_write_raw;
  assign RegWrite  = reset & reg_write_raw;
  assign IllegalOp = reset & illegal_raw;
  assign InstrDone = reset & done_raw;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues expected per-cycle output
// vectors, a negedge monitor pops and compares them against the DUT.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OPCode, Funct;
  logic       Z;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUCtrl;
  logic       IllegalOp, InstrDone;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk       (clk),
    .reset     (reset),
    .OPCode    (OPCode),
    .Funct     (Funct),
    .Z         (Z),
    .PCEn      (PCEn),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .PCSrc     (PCSrc),
    .ALUCtrl   (ALUCtrl),
    .IllegalOp (IllegalOp),
    .InstrDone (InstrDone)
  );

  typedef struct packed {
    logic       pcen, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, src_a;
    logic [1:0] src_b, pc_src;
    logic [2:0] alu;
    logic       illegal, done;
  } vec_t;

  typedef struct {
    string name;
    vec_t  v;
  } exp_t;

  localparam int SRst = 0, SFetch = 1, SDecode = 2, SDecIll = 3, SMemAdr = 4, SMemRd = 5;
  localparam int SMemWb = 6, SMemWr = 7, SExec = 8, SAluWb = 9, SBranch = 10;
  localparam int SAddiEx = 11, SAddiWb = 12, SJump = 13;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Expected outputs per state, written out from the state table.
  function automatic vec_t exp_vec(input int s, input logic z, input logic [2:0] alu);
    vec_t e;
    e     = '0;
    e.alu = 3'b010;
    case (s)
      SRst:    e.src_b = 2'b01;
      SFetch:  begin e.ir_write = 1; e.src_b = 2'b01; e.pcen = 1; end
      SDecode: e.src_b = 2'b11;
      SDecIll: begin e.src_b = 2'b11; e.illegal = 1; end
      SMemAdr: begin e.src_a = 1; e.src_b = 2'b10; end
      SMemRd:  e.iord = 1;
      SMemWb:  begin e.mem_to_reg = 1; e.reg_write = 1; e.done = 1; end
      SMemWr:  begin e.iord = 1; e.mem_write = 1; e.done = 1; end
      SExec:   begin e.src_a = 1; e.alu = alu; end
      SAluWb:  begin e.reg_dst = 1; e.reg_write = 1; e.done = 1; end
      SBranch: begin e.src_a = 1; e.alu = 3'b110; e.pc_src = 2'b01; e.pcen = z; e.done = 1; end
      SAddiEx: begin e.src_a = 1; e.src_b = 2'b10; end
      SAddiWb: begin e.reg_write = 1; e.done = 1; end
      SJump:   begin e.pc_src = 2'b10; e.pcen = 1; e.done = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic push(input string name, input int s, input logic [2:0] alu = 3'b010);
    exp_t x;
    x.name = name;
    x.v    = exp_vec(s, Z, alu);
    q.push_back(x);
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      vec_t act;
      x   = q.pop_front();
      act = '{PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
              ALUSrcB, PCSrc, ALUCtrl, IllegalOp, InstrDone};
      n_vec++;
      if (act !== x.v) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", x.name, act, x.v);
      end
    end
  end

  logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] alu_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    reset  = 1'b0;
    OPCode = 6'b100011;
    Funct  = 6'b000000;
    Z      = 1'b0;
    @(posedge clk);
    #1;
    push("init_rst0", SRst);
    push("init_rst1", SRst);
    run(2);
    reset = 1'b1;

    // lw with Z held high: PCEn must only follow the FETCH PCWrite.
    Z = 1'b1;
    push("lw_fetch", SFetch); push("lw_decode", SDecode); push("lw_memadr", SMemAdr);
    push("lw_memrd", SMemRd); push("lw_memwb", SMemWb);
    run(5);
    Z = 1'b0;

    // lw aborted by reset in MEMRD.
    push("ab_fetch", SFetch); push("ab_decode", SDecode); push("ab_memadr", SMemAdr);
    run(3);
    reset = 1'b0;
    push("ab_rst0", SRst); push("ab_rst1", SRst); push("ab_rst2", SRst);
    run(3);
    reset = 1'b1;
    push("post_fetch", SFetch); push("post_decode", SDecode); push("post_memadr", SMemAdr);
    push("post_memrd", SMemRd); push("post_memwb", SMemWb);
    run(5);

    // R-type, every supported funct.
    OPCode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      Funct = fn_tab[i];
      push("r_fetch", SFetch); push("r_decode", SDecode);
      push("r_execute", SExec, alu_tab[i]); push("r_aluwb", SAluWb);
      run(4);
    end

    OPCode = 6'b000100;
    Funct  = 6'b101010;
    for (int i = 0; i < 2; i++) begin
      Z = (i == 0);
      push("beq_fetch", SFetch); push("beq_decode", SDecode); push("beq_branch", SBranch);
      run(3);
    end
    Z = 1'b0;

    OPCode = 6'b000010;
    push("j_fetch", SFetch); push("j_decode", SDecode); push("j_jump", SJump);
    run(3);

    OPCode = 6'b101011;
    push("sw_fetch", SFetch); push("sw_decode", SDecode); push("sw_memadr", SMemAdr);
    push("sw_memwr", SMemWr);
    run(4);

    OPCode = 6'b001000;
    push("addi_fetch", SFetch); push("addi_decode", SDecode); push("addi_ex", SAddiEx);
    push("addi_wb", SAddiWb);
    run(4);

    OPCode = 6'b111111;
    push("ill_op_fetch", SFetch); push("ill_op_decode", SDecIll);
    run(2);
    OPCode = 6'b000000;
    Funct  = 6'b000001;
    push("ill_fn_fetch", SFetch); push("ill_fn_decode", SDecIll);
    run(2);

    // Back to a legal instruction to confirm illegal ops returned to FETCH.
    OPCode = 6'b000010;
    push("after_ill_fetch", SFetch); push("after_ill_decode", SDecode);
    push("after_ill_jump", SJump);
    run(3);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
